address_unit: RTL
=================

Name: address_unit

Overview:
- Parametrised successor of the PC/AR address block; generates instruction and data addresses for the core.
- Holds one program counter and NUM_AR address registers.
- A byte-serial temp assembler collects an ADDR_W-bit operand from the DATA_W-bit data bus over several cycles.
- Sits between the instruction decoder (control strobes) and the memory address mux.

Parameters:
ADDR_W, 16, width of PC, address registers and temp.
DATA_W, 8, width of the data bus; one byte lane per tmpWr.
NUM_AR, 2, number of address registers (1..8).
RESET_VECTOR, 0, reset value of PC and all ARs.
(Derived: BYTES = ceil(ADDR_W/DATA_W); SEL_W = max(1, clog2(NUM_AR)).)

Ports:
clk  input  1  clock, rising edge
n_rst  input  1  reset, asynchronous, active-low
data  input  DATA_W  data bus byte for the temp assembler
tmpWr  input  1  write data into the next temp byte lane
tmpClr  input  1  restart the temp sequence
srcSel  input  1  load source: 0 = temp, 1 = programCounter
pcInc  input  1  PC <= PC + 1
pcLoad  input  1  PC <= source
arSel  input  SEL_W  index of the address register being operated on and output
arInc  input  1  selected AR + 1
arDec  input  1  selected AR - 1
arLoad  input  1  selected AR <= source
tmpFull  output  1  all BYTES lanes written since the last restart
programCounter  output  ADDR_W  current PC
addressRegister  output  ADDR_W  AR[arSel]; 0 if arSel >= NUM_AR

Behaviour:
- Clock and reset: one clock clk; n_rst is asynchronous and active-low.
- Reset values: PC and all ARs = RESET_VECTOR; temp = 0; byte pointer = 0; tmpFull = 0.
- Registered updates: all updates happen on the rising clk edge. Outputs are registers or AR[arSel] read through a mux; no other combinational path.
- Temp assembler:
  - tmpWr writes data into lane bptr (bits bptr*DATA_W upward) and increments bptr.
  - The write to lane BYTES-1 sets tmpFull = 1 and bptr = 0. Bits of the last lane above ADDR_W are discarded.
  - tmpWr while tmpFull = 1 clears tmpFull and writes lane 0, so back-to-back operands need no tmpClr.
  - tmpClr sets bptr = 0 and tmpFull = 0 but leaves temp contents unchanged. tmpClr has priority over tmpWr in the same cycle; that tmpWr is dropped.
- Load source: srcSel = 0 selects the full temp value; srcSel = 1 selects the PC value before this edge.
  - Loading from a partly filled temp is legal and uses the current contents, so stale upper lanes are possible.
  - Any pcLoad or arLoad with srcSel = 0 consumes the temp: bptr = 0, tmpFull = 0.
  - If tmpWr occurs in the same cycle as a consuming load, the load uses the old temp, and the write goes to lane 0 of a new sequence (bptr = 1 afterwards).
- PC: priority pcInc > pcLoad. Arithmetic is modulo 2^ADDR_W (all-ones + 1 = 0).
- Selected AR: priority arInc > arDec > arLoad. Inc and dec wrap modulo 2^ADDR_W (0 - 1 = all-ones). Unselected ARs hold their values.
- Out-of-range arSel (>= NUM_AR): AR strobes are ignored, addressRegister = 0, and the temp is not consumed.
- Combined PC and AR operations:
  - PC and AR operations are independent and may occur in the same cycle.
  - arLoad with srcSel = 1 together with pcInc or pcLoad loads the pre-update PC.
- Reset mid-sequence: asserting n_rst during a temp sequence or any operation aborts it immediately; all state returns to reset values.

Optional Feature:
PC_REL_EN
- Defined: adds input pcRel (1 bit). pcRel sets PC <= PC + sign-extended temp lane 0 (DATA_W bits), modulo 2^ADDR_W.
  - PC priority becomes pcInc > pcRel > pcLoad.
  - pcRel consumes the temp like a srcSel = 0 load.
- Undefined: the pcRel port does not exist and no relative adder is built.

Test Plan:
- Reset: hold n_rst = 0, then release -> PC = 0, AR0 = AR1 = 0, tmpFull = 0; an asynchronous assert mid-cycle clears PC immediately.
- Temp assembly: tmpWr data = 0x34, then tmpWr 0x12 -> tmpFull = 1 after the second edge; then pcLoad with srcSel = 0 -> PC = 0x1234 and tmpFull = 0.
- Wrap: load AR1 = 0xFFFF via temp, then arInc with arSel = 1 -> AR1 = 0x0000 while AR0 is unchanged; then arDec -> AR1 = 0xFFFF.
- Priority and combined cycle:
  - With PC = 0x0010, pcInc + pcLoad -> PC = 0x0011.
  - In the same cycle, arLoad with srcSel = 1 -> AR0 = 0x0010.
  - arInc + arDec + arLoad -> AR increments only.
- Temp consume with concurrent write: tmpFull = 1 with temp = 0xABCD; arLoad (srcSel = 0) + tmpWr data = 0x55 -> AR0 = 0xABCD, bptr = 1, temp lane 0 = 0x55, tmpFull = 0.
- PC_REL_EN: PC = 0x0100, temp lane 0 = 0xFE, pcRel -> PC = 0x00FE; temp lane 0 = 0x05 -> PC = 0x0103. With the macro undefined, the port is absent (compile check).

Source files
------------

// File: rtl/address_unit.sv
// ---------------------------------------------------------------------------
// address_unit
//   Generates instruction and data addresses for the core. It holds one
//   program counter and NUM_AR address registers. A byte-serial temp
//   assembler gathers an ADDR_W-bit operand from the DATA_W-bit bus, one
//   lane per tmpWr.
//
// Optional feature macro: PC_REL_EN
//   When defined, this adds the pcRel input, which moves the PC by the
//   sign-extended value of temp lane 0.
//
// Ports:
//   clk, n_rst       clock (rising edge), asynchronous active-low reset
//   data             byte written into the next temp lane
//   tmpWr / tmpClr   temp lane write / restart of the temp sequence
//   srcSel           load source: 0 = temp, 1 = current PC
//   pcInc / pcLoad   PC increment / PC load (pcInc wins)
//   pcRel            (PC_REL_EN only) PC += sext(temp lane 0)
//   arSel            index of the address register being operated on
//   arInc/arDec/arLoad  ops on the selected AR (inc > dec > load)
//   tmpFull          all temp lanes written since the last restart
//   programCounter   current PC
//   addressRegister  AR[arSel], or 0 when arSel is out of range
// ---------------------------------------------------------------------------
module address_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NUM_AR = 2,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    localparam int SEL_W = (NUM_AR > 1) ? $clog2(NUM_AR) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] data,
    input  logic              tmpWr,
    input  logic              tmpClr,
    input  logic              srcSel,
    input  logic              pcInc,
    input  logic              pcLoad,
`ifdef PC_REL_EN
    input  logic              pcRel,
`endif
    input  logic [SEL_W-1:0]  arSel,
    input  logic              arInc,
    input  logic              arDec,
    input  logic              arLoad,
    output logic              tmpFull,
    output logic [ADDR_W-1:0] programCounter,
    output logic [ADDR_W-1:0] addressRegister
);

    localparam int BYTES  = (ADDR_W + DATA_W - 1) / DATA_W;
    localparam int WIDE_W = BYTES * DATA_W;
    localparam int PTR_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ar [NUM_AR];
    logic [ADDR_W-1:0] r_temp;
    logic [PTR_W-1:0]  r_bptr;
    logic              r_full;

    logic              w_ar_ok;
    logic              w_rel;
    logic              w_consume;
    logic [PTR_W-1:0]  w_lane;
    logic              w_last;
    logic [WIDE_W-1:0] w_wide;
    logic [ADDR_W-1:0] w_src;
    logic [ADDR_W-1:0] w_ar_out;

`ifdef PC_REL_EN
    assign w_rel = pcRel;
`else
    assign w_rel = 1'b0;
`endif

    // An out-of-range arSel disables the AR strobes entirely, including
    // their consumption of the temp.
    assign w_ar_ok   = (int'(arSel) < NUM_AR);
    assign w_consume = (!srcSel && (pcLoad || (arLoad && w_ar_ok))) || w_rel;
    assign w_src     = srcSel ? r_pc : r_temp;

    // A write restarts at lane 0 when the previous operand is complete or
    // is being consumed this cycle. A consuming load still sees the old
    // r_temp because r_temp only changes at the edge.
    always_comb begin
        w_lane = (w_consume || r_full) ? '0 : r_bptr;
        w_last = (int'(w_lane) == BYTES - 1);
        w_wide = WIDE_W'(r_temp);
        w_wide[int'(w_lane)*DATA_W +: DATA_W] = data;
    end

    always_comb begin
        w_ar_out = '0;
        for (int i = 0; i < NUM_AR; i++)
            if (int'(arSel) == i) w_ar_out = r_ar[i];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_temp <= '0;
            r_bptr <= '0;
            r_full <= 1'b0;
        end else if (tmpClr) begin
            // Contents stay put and any simultaneous tmpWr is dropped.
            r_bptr <= '0;
            r_full <= 1'b0;
        end else if (tmpWr) begin
            r_temp <= w_wide[ADDR_W-1:0];
            r_bptr <= w_last ? '0 : w_lane + PTR_W'(1);
            r_full <= w_last;
        end else if (w_consume) begin
            r_bptr <= '0;
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_pc <= RESET_VECTOR;
        else if (pcInc)
            r_pc <= r_pc + ADDR_W'(1);
        else if (w_rel)
            r_pc <= r_pc + ADDR_W'($signed(r_temp[DATA_W-1:0]));
        else if (pcLoad)
            r_pc <= w_src;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_AR; i++) r_ar[i] <= RESET_VECTOR;
        end else begin
            for (int i = 0; i < NUM_AR; i++) begin
                if (int'(arSel) == i) begin
                    if (arInc)       r_ar[i] <= r_ar[i] + ADDR_W'(1);
                    else if (arDec)  r_ar[i] <= r_ar[i] - ADDR_W'(1);
                    else if (arLoad) r_ar[i] <= w_src;
                end
            end
        end
    end

    assign tmpFull         = r_full;
    assign programCounter  = r_pc;
    assign addressRegister = w_ar_out;

endmodule
